uart_fifo_bridge: RTL
=====================

UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per word on every data port.
REQ-002 SHALL have parameter RX_DEPTH, default 32: RX FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter TX_DEPTH, default 32: TX FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter AF_MARGIN, default 4: rx_almost_full asserts when free RX entries <= AF_MARGIN.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, in this port order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- loopback  in  1  1 = RX FIFO output feeds TX FIFO input; client ports idle.
- uart_rx_data  in  DATA_WIDTH  byte from UART receiver.
- uart_rx_valid  in  1  uart_rx_data valid.
- uart_rx_ready  out  1  bridge can accept (= RX FIFO not full).
- uart_tx_data  out  DATA_WIDTH  byte to UART transmitter.
- uart_tx_valid  out  1  uart_tx_data valid.
- uart_tx_ready  in  1  transmitter accepts.
- client_rx_data  out  DATA_WIDTH  received word to client.
- client_rx_valid  out  1  client_rx_data valid.
- client_rx_ready  in  1  client consumes.
- client_tx_data  in  DATA_WIDTH  word from client.
- client_tx_valid  in  1  client_tx_data valid.
- client_tx_ready  out  1  bridge can accept (= TX FIFO not full, loopback=0).
- rx_count  out  $clog2(RX_DEPTH+1)  words held in RX FIFO.
- tx_count  out  $clog2(TX_DEPTH+1)  words held in TX FIFO.
- rx_almost_full  out  1  see REQ-004.
- rx_overflow  out  1  sticky: UART byte offered while RX FIFO full.
- clear_overflow  in  1  synchronous clear of rx_overflow.

Function
REQ-006 Every handshake SHALL complete on a rising edge with valid && ready both high; once raised, a valid SHALL hold with stable data until accepted.
REQ-007 RX FIFO write SHALL occur on uart_rx_valid && uart_rx_ready; a byte offered while full SHALL be dropped and rx_overflow SHALL set next cycle.
REQ-008 rx_overflow SHALL clear on clear_overflow; if set and clear coincide, set SHALL win.
REQ-009 Each FIFO read side SHALL drive a one-entry output register (first-word-fall-through): a word written at edge N into an empty FIFO SHALL appear valid at edge N+2.
REQ-010 Output register SHALL refill in the same cycle it is consumed when its FIFO is non-empty, sustaining one word per cycle.
REQ-011 Full FIFO SHALL block writes even with a simultaneous read; empty FIFO SHALL block reads; simultaneous read+write when neither boundary applies SHALL leave count unchanged.
REQ-012 Pointers SHALL wrap modulo depth; full/empty SHALL be distinguished by an extra pointer bit.
REQ-013 rx_count/tx_count SHALL include words in the output register and update the cycle after each handshake.
REQ-014 With loopback=1 the RX output register SHALL write the TX FIFO when TX not full; client_rx_valid and client_tx_ready SHALL be 0.
REQ-015 loopback change SHALL take effect at the next edge; no word SHALL be lost or duplicated across the switch.
REQ-016 Word order SHALL be preserved end to end in both modes.

Reset
REQ-017 rst_n low SHALL immediately empty both FIFOs, clear output registers, and force all valid/ready outputs, counts, rx_almost_full and rx_overflow to 0; data outputs SHALL be 0.
REQ-018 Reset asserted mid-transfer SHALL discard all in-flight words; uart_rx_ready and client_tx_ready SHALL rise on the first edge after rst_n deasserts.

Structure
REQ-019 Shared package SHALL hold the default DATA_WIDTH, default depths and a ceil-log2 helper function.
REQ-020 One sub-module fifo (parametrised width/depth, async active-low reset, registered read) SHALL be instantiated twice.

Verification
REQ-021 Single byte 0xA5 on UART RX at edge N -> client_rx_valid with 0xA5 at N+2; rx_count 1 then 0 after consume.
REQ-022 33 UART bytes 0x00..0x20, client_rx_ready=0, depths 32 -> 0x20 dropped, rx_overflow=1, readback 0x00..0x1F in order.
REQ-023 rx_count reaching 28 -> rx_almost_full=1; at 27 -> 0.
REQ-024 loopback=1, UART RX 0x11,0x22,0x33, uart_tx_ready=1 -> uart_tx_data 0x11,0x22,0x33 in order; client ports idle.
REQ-025 Client writes 40 words with uart_tx_ready toggling -> client_tx_ready drops at tx_count 32; all 40 emitted in order.
REQ-026 rst_n pulsed low with 10 words buffered -> all outputs 0 immediately; no stale word emitted afterward.

Source files
------------

// File: rtl/uart_fifo_bridge_pkg.sv
// Shared defaults and helpers for the UART/client FIFO bridge.
package uart_fifo_bridge_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_RX_DEPTH   = 32;
  localparam int DEF_TX_DEPTH   = 32;
  localparam int DEF_AF_MARGIN  = 4;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_fifo_bridge_fifo.sv
// Synchronous FIFO with a first-word-fall-through output register.
// Capacity counts the output register, so DEPTH words total.
module uart_fifo_bridge_fifo
  import uart_fifo_bridge_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_RX_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            i_wdata,
  input  logic                        i_wvalid,
  output logic                        o_wready,
  output logic [WIDTH-1:0]            o_rdata,
  output logic                        o_rvalid,
  input  logic                        i_rready,
  output logic [clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH+1);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic             r_alive;

  logic w_full;
  logic w_mem_empty;
  logic w_push;
  logic w_pop;
  logic w_load;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
  // r_alive holds ready low until the first edge out of reset
  assign o_wready    = r_alive && !w_full;
  assign w_push      = i_wvalid && o_wready;
  assign w_pop       = r_rvalid && i_rready;
  assign w_load      = !w_mem_empty && (!r_rvalid || i_rready);

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
  assign o_count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_rdata  <= r_mem[r_rd_ptr[AW-1:0]];
        r_rvalid <= 1'b1;
      end else if (w_pop) begin
        r_rvalid <= 1'b0;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Bridges a UART byte stream to a client port through RX/TX FIFOs,
// with an optional loopback from the RX output into the TX FIFO.
module uart_fifo_bridge
  import uart_fifo_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RX_DEPTH   = DEF_RX_DEPTH,
  parameter int TX_DEPTH   = DEF_TX_DEPTH,
  parameter int AF_MARGIN  = DEF_AF_MARGIN
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           loopback,
  input  logic [DATA_WIDTH-1:0]          uart_rx_data,
  input  logic                           uart_rx_valid,
  output logic                           uart_rx_ready,
  output logic [DATA_WIDTH-1:0]          uart_tx_data,
  output logic                           uart_tx_valid,
  input  logic                           uart_tx_ready,
  output logic [DATA_WIDTH-1:0]          client_rx_data,
  output logic                           client_rx_valid,
  input  logic                           client_rx_ready,
  input  logic [DATA_WIDTH-1:0]          client_tx_data,
  input  logic                           client_tx_valid,
  output logic                           client_tx_ready,
  output logic [clog2(RX_DEPTH+1)-1:0]   rx_count,
  output logic [clog2(TX_DEPTH+1)-1:0]   tx_count,
  output logic                           rx_almost_full,
  output logic                           rx_overflow,
  input  logic                           clear_overflow
);

  localparam int RCW = clog2(RX_DEPTH+1);

  logic [DATA_WIDTH-1:0] w_rx_data;
  logic                  w_rx_valid;
  logic                  w_rx_ready;
  logic [DATA_WIDTH-1:0] w_tx_wdata;
  logic                  w_tx_wvalid;
  logic                  w_tx_wready;
  logic                  w_drop;
  logic                  r_overflow;

  // Loopback steers the RX output straight into the TX FIFO
  assign w_rx_ready  = loopback ? w_tx_wready : client_rx_ready;
  assign w_tx_wdata  = loopback ? w_rx_data   : client_tx_data;
  assign w_tx_wvalid = loopback ? w_rx_valid  : client_tx_valid;

  assign client_rx_data  = w_rx_data;
  assign client_rx_valid = w_rx_valid && !loopback;
  assign client_tx_ready = w_tx_wready && !loopback;

  assign rx_almost_full = (int'(rx_count) + AF_MARGIN) >= RX_DEPTH;
  assign w_drop         = uart_rx_valid && (rx_count == RCW'(RX_DEPTH));
  assign rx_overflow    = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  uart_fifo_bridge_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wdata  (uart_rx_data),
    .i_wvalid (uart_rx_valid),
    .o_wready (uart_rx_ready),
    .o_rdata  (w_rx_data),
    .o_rvalid (w_rx_valid),
    .i_rready (w_rx_ready),
    .o_count  (rx_count)
  );

  uart_fifo_bridge_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wdata  (w_tx_wdata),
    .i_wvalid (w_tx_wvalid),
    .o_wready (w_tx_wready),
    .o_rdata  (uart_tx_data),
    .o_rvalid (uart_tx_valid),
    .i_rready (uart_tx_ready),
    .o_count  (tx_count)
  );

endmodule
